// File: rtl/rr_bus_mux_pkg.sv
// Shared constants, FSM encoding and index helper for the round-robin bus mux.
// Combinational-only content; no state and no flow control.
package rr_bus_mux_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
    return (i + 32'd1 >= n) ? 32'd0 : i + 32'd1;
  endfunction

endpackage

// File: rtl/rr_bus_mux_pick.sv
// Round-robin winner search: first requester at or after base, optionally skipping one index.
// Purely combinational, zero latency; no backpressure.
module rr_pick #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] base,
  input  logic             excl_en,
  input  logic [SEL_W-1:0] excl_idx,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  always_comb begin
    int             j;
    logic [SEL_W-1:0] jj;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < N; k++) begin
      j  = (int'(base) + k) % N;
      jj = SEL_W'(j);
      if (!found && req[jj] && !(excl_en && (jj == excl_idx))) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/rr_bus_mux.sv
// N-source registered bus mux with round-robin grant and optional hold-limit preemption.
// One-cycle latency from req/in_data to grant/bus_out; sources wait on req, no backpressure.
module rr_bus_mux
  import rr_bus_mux_pkg::*;
#(
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  N        = 4,
  parameter int  MAX_HOLD = 0,
  localparam int SEL_W    = $clog2(N)
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       grant,
  output logic [SEL_W-1:0]   grant_idx,
  output logic               bus_valid,
  output logic [WIDTH-1:0]   bus_out
);

  localparam int              HC_W     = $clog2(MAX_HOLD + 2);
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);

  state_e           state;
  logic [SEL_W-1:0] ptr;
  logic [HC_W-1:0]  hold_cnt;
  logic             found;
  logic [SEL_W-1:0] win;
  logic             preempt;
  logic             keep;

  // While granted, ptr already equals holder+1, so the same base serves both states.
  rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
    .req      (req),
    .base     (ptr),
    .excl_en  (state == GRANT),
    .excl_idx (grant_idx),
    .found    (found),
    .idx      (win)
  );

  assign preempt = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && found;
  assign keep    = (state == GRANT) && req[grant_idx] && !preempt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      bus_valid <= 1'b0;
      bus_out   <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else if (keep) begin
      bus_out <= in_data[grant_idx*WIDTH +: WIDTH];
      if ((MAX_HOLD != 0) && (hold_cnt != HOLD_MAX))
        hold_cnt <= hold_cnt + 1'b1;
    end else if (found) begin
      // Fresh grant from IDLE or a bubble-free handover.
      state     <= GRANT;
      grant     <= N'(1) << win;
      grant_idx <= win;
      bus_valid <= 1'b1;
      bus_out   <= in_data[win*WIDTH +: WIDTH];
      ptr       <= SEL_W'(wrap_inc(32'(win), N));
      hold_cnt  <= HC_W'(1);
    end else begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      bus_valid <= 1'b0;
      bus_out   <= '0;
    end
  end

endmodule

// File: tb/tb_rr_bus_mux.sv
// Scoreboard bench for rr_bus_mux: a hold-limited instance (MAX_HOLD=4) and a no-limit instance.
module tb_rr_bus_mux;

  logic         clk = 1'b0;
  logic         clr_n;
  logic [3:0]   req, req_nl;
  logic [31:0]  d [4];
  logic [127:0] in_data;

  logic [3:0]  grant,     nl_grant;
  logic [1:0]  grant_idx, nl_grant_idx;
  logic        bus_valid, nl_bus_valid;
  logic [31:0] bus_out,   nl_bus_out;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  g;
    logic [1:0]  i;
    logic        v;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  assign in_data = {d[3], d[2], d[1], d[0]};

  rr_bus_mux #(.WIDTH(32), .N(4), .MAX_HOLD(4)) dut (
    .clk(clk), .clr_n(clr_n), .req(req), .in_data(in_data),
    .grant(grant), .grant_idx(grant_idx), .bus_valid(bus_valid), .bus_out(bus_out)
  );

  rr_bus_mux #(.WIDTH(32), .N(4), .MAX_HOLD(0)) dut_nl (
    .clk(clk), .clr_n(clr_n), .req(req_nl), .in_data(in_data),
    .grant(nl_grant), .grant_idx(nl_grant_idx), .bus_valid(nl_bus_valid), .bus_out(nl_bus_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] i, input logic v,
                              input logic [31:0] b);
    exp_t e;
    e.g = g; e.i = i; e.v = v; e.b = b;
    return e;
  endfunction

  // Drive one request pattern at the falling edge, score the outputs just after the next rising edge.
  task automatic step(input logic [3:0] r, input exp_t e, input bit nl, input string tag);
    exp_t x;
    exp_t o;
    @(negedge clk);
    req    = nl ? 4'b0000 : r;
    req_nl = nl ? r : 4'b0000;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = nl ? {nl_grant, nl_grant_idx, nl_bus_valid, nl_bus_out}
           : {grant, grant_idx, bus_valid, bus_out};
    if (sb.size() == 0) begin
      chk({tag, "/sb_empty"}, 64'd1, 64'd0);
    end else begin
      x = sb.pop_front();
      chk({tag, "/grant"},     64'(o.g), 64'(x.g));
      chk({tag, "/grant_idx"}, 64'(o.i), 64'(x.i));
      chk({tag, "/bus_valid"}, 64'(o.v), 64'(x.v));
      chk({tag, "/bus_out"},   64'(o.b), 64'(x.b));
    end
  endtask

  // Assert reset between edges; outputs must clear before any clock edge.
  task automatic rst_mid(input string tag);
    #1 clr_n = 1'b0;
    #1;
    chk({tag, "/grant"},     64'(grant),     64'd0);
    chk({tag, "/grant_idx"}, 64'(grant_idx), 64'd0);
    chk({tag, "/bus_valid"}, 64'(bus_valid), 64'd0);
    chk({tag, "/bus_out"},   64'(bus_out),   64'd0);
    @(negedge clk);
    clr_n  = 1'b1;
    req    = 4'b0000;
    req_nl = 4'b0000;
  endtask

  exp_t IDLE_E, G0, G1, G2, G3;

  initial begin
    logic [3:0] mg_req [2];
    IDLE_E = mk(4'b0000, 2'd0, 1'b0, 32'h0);
    G0     = mk(4'b0001, 2'd0, 1'b1, 32'h1);
    G1     = mk(4'b0010, 2'd1, 1'b1, 32'h2);
    G2     = mk(4'b0100, 2'd2, 1'b1, 32'h80000000);
    G3     = mk(4'b1000, 2'd3, 1'b1, 32'h7FFFFFFF);
    mg_req = '{4'b1100, 4'b0100};

    clr_n  = 1'b0;
    req    = 4'b1111;
    req_nl = 4'b0000;
    d      = '{32'h1, 32'h2, 32'h80000000, 32'h7FFFFFFF};
    repeat (2) @(posedge clk);
    #1;
    chk("por/grant",     64'(grant),     64'd0);
    chk("por/grant_idx", 64'(grant_idx), 64'd0);
    chk("por/bus_valid", 64'(bus_valid), 64'd0);
    chk("por/bus_out",   64'(bus_out),   64'd0);
    chk("por/nl_grant",  64'(nl_grant),  64'd0);
    @(negedge clk);
    clr_n = 1'b1;

    step(4'b1111, G0, 1'b0, "rst_first");
    req = 4'b1111;
    rst_mid("rst_async");
    step(4'b1111, G0, 1'b0, "rst_regrant");
    step(4'b0000, IDLE_E, 1'b0, "drop_all");

    // Single source; the other channels carry X that must never reach the bus.
    d[0] = 'x;
    d[3] = 'x;
    step(4'b0010, G1, 1'b0, "single");
    d[1] = 32'h7FFFFFFF;
    step(4'b0010, mk(4'b0010, 2'd1, 1'b1, 32'h7FFFFFFF), 1'b0, "single_follow");
    step(4'b0000, IDLE_E, 1'b0, "single_drop");
    d = '{32'h1, 32'h2, 32'h80000000, 32'h7FFFFFFF};

    rst_mid("rst_rr");
    step(4'b1111, G0, 1'b0, "rr0");
    step(4'b1110, G1, 1'b0, "rr1");
    step(4'b1101, G2, 1'b0, "rr2");
    step(4'b1011, G3, 1'b0, "rr3");
    step(4'b0111, G0, 1'b0, "rr4");
    step(4'b0000, IDLE_E, 1'b0, "rr_idle");

    rst_mid("rst_pre");
    for (int k = 0; k < 16; k++)
      step(4'b0011, ((k / 4) % 2 == 1) ? G1 : G0, 1'b0, $sformatf("preempt%0d", k));
    for (int k = 0; k < 22; k++)
      step(4'b0001, G0, 1'b0, $sformatf("sole%0d", k));
    step(4'b0000, IDLE_E, 1'b0, "sole_idle");

    for (int k = 0; k < 50; k++)
      step(4'b0011, G0, 1'b1, $sformatf("nolimit%0d", k));
    step(4'b0000, IDLE_E, 1'b1, "nolimit_idle");

    // Mid-grant reset; 4'b1100 tells a restarted ptr (ch2) apart from a stale one (ch3).
    for (int m = 0; m < 2; m++) begin
      rst_mid($sformatf("mg_pre%0d", m));
      step(4'b0100, G2, 1'b0, $sformatf("mg_grant%0d", m));
      rst_mid($sformatf("mg_rst%0d", m));
      step(mg_req[m], G2, 1'b0, $sformatf("mg_regrant%0d", m));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
